// File: rtl/tt_um_qsn_pipe.sv
// Pipelined quasi-cyclic shift network for the LDPC datapath.
// Rotates the first z LLRs of a ZMAX-element vector, one barrel bit per stage.
module tt_um_qsn_pipe #(
    parameter int ZMAX = 8,
    parameter int W    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ZMAX*W-1:0]               in_data,
    input  logic [$clog2(ZMAX+1)-1:0]       in_z,
    input  logic [$clog2(ZMAX)-1:0]         in_shift,
    input  logic                            in_inv,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ZMAX*W-1:0]               out_data,
    output logic                            out_err
);

    localparam int SHIFT_W = $clog2(ZMAX);
    localparam int Z_W     = $clog2(ZMAX+1);
    localparam int LAT     = SHIFT_W + 1;

    logic                 v   [LAT];
    logic                 err [LAT];
    logic [ZMAX*W-1:0]    d   [LAT];
    logic [Z_W-1:0]       z   [SHIFT_W];
    logic [SHIFT_W-1:0]   sh  [SHIFT_W];
    logic                 inv [SHIFT_W];

    logic                 en;
    logic                 in_err;
    logic [ZMAX*W-1:0]    in_masked;

    function automatic logic [ZMAX*W-1:0] rot(
        input logic [ZMAX*W-1:0] din,
        input logic [Z_W-1:0]    zz,
        input int                r,
        input logic              dir
    );
        logic [ZMAX*W-1:0] o;
        int zi;
        int j;
        o  = '0;
        zi = int'(zz);
        for (int i = 0; i < ZMAX; i++) begin
            if (i < zi) begin
                j = dir ? i - r : i + r;
                if (j >= zi)
                    j = j - zi;
                else if (j < 0)
                    j = j + zi;
                o[i*W +: W] = din[j*W +: W];
            end
        end
        return o;
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign in_err = (in_z == '0) || (in_z > Z_W'(ZMAX)) ||
                    (Z_W'(in_shift) >= in_z);

    // Lanes at or above z are cleared up front so rotation never sees them.
    always_comb begin
        in_masked = '0;
        for (int i = 0; i < ZMAX; i++) begin
            if (i < int'(in_z))
                in_masked[i*W +: W] = in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                v[k]   <= 1'b0;
                err[k] <= 1'b0;
                d[k]   <= '0;
            end
            for (int k = 0; k < SHIFT_W; k++) begin
                z[k]   <= '0;
                sh[k]  <= '0;
                inv[k] <= 1'b0;
            end
        end else if (en) begin
            v[0]   <= in_valid;
            err[0] <= in_err;
            d[0]   <= in_err ? '0 : in_masked;
            z[0]   <= in_z;
            sh[0]  <= in_shift;
            inv[0] <= in_inv;
            for (int k = 0; k < SHIFT_W; k++) begin
                v[k+1]   <= v[k];
                err[k+1] <= err[k];
                d[k+1]   <= rot(d[k], z[k],
                                (sh[k][0] && !err[k]) ? (1 << k) : 0,
                                inv[k]);
            end
            // Residual shift moves down so each stage tests its bit 0.
            for (int k = 0; k < SHIFT_W-1; k++) begin
                z[k+1]   <= z[k];
                sh[k+1]  <= sh[k] >> 1;
                inv[k+1] <= inv[k];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_data  = d[LAT-1];
    assign out_err   = err[LAT-1];

endmodule
